// File: rtl/fb_pkg.sv
// Shared constants, register map and FSM state type for the framebuffer fill engine.
package fb_pkg;

   localparam int WORDS_PER_LINE = 20;
   localparam int LINES          = 480;
   localparam int FB_AW          = 15;

   localparam logic [9:0]       LAST_LINE   = 10'(LINES - 1);
   localparam logic [4:0]       LAST_WORD   = 5'(WORDS_PER_LINE - 1);
   localparam logic [FB_AW-1:0] LINE_STRIDE = FB_AW'(WORDS_PER_LINE);

   localparam logic [1:0] REG_PATTERN = 2'd0;
   localparam logic [1:0] REG_Y       = 2'd1;
   localparam logic [1:0] REG_W       = 2'd2;
   localparam logic [1:0] REG_CTRL    = 2'd3;

   localparam int STAT_BUSY = 0;
   localparam int STAT_ERR  = 1;

   typedef enum logic {IDLE, FILL} state_e;

   // y*20 as y*16 + y*4 so no multiplier is inferred.
   function automatic logic [FB_AW-1:0] row_base_of(input logic [9:0] y);
      return (FB_AW'(y) << 4) + (FB_AW'(y) << 2);
   endfunction

endpackage

// File: rtl/fb_rect_walker.sv
// Row/column walker over a word rectangle; addr is the word following the current one.
module fb_rect_walker
   import fb_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             advance,
   input  logic [9:0]       y0,
   input  logic [9:0]       y1,
   input  logic [4:0]       w0,
   input  logic [4:0]       w1,
   output logic [FB_AW-1:0] addr,
   output logic             last
);

   logic [FB_AW-1:0] row_base;
   logic [9:0]       row;
   logic [4:0]       col;
   logic             end_of_row;

   assign end_of_row = (col == w1);
   assign last       = end_of_row && (row == y1);

   always_comb begin
      if (end_of_row) addr = row_base + LINE_STRIDE + FB_AW'(w0);
      else            addr = row_base + FB_AW'(col) + FB_AW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_base <= '0;
         row      <= '0;
         col      <= '0;
      end else if (load) begin
         row_base <= row_base_of(y0);
         row      <= y0;
         col      <= w0;
      end else if (advance) begin
         if (end_of_row) begin
            col      <= w0;
            row      <= row + 10'd1;
            row_base <= row_base + LINE_STRIDE;
         end else begin
            col      <= col + 5'd1;
         end
      end
   end

endmodule

// File: rtl/fb_fill_engine.sv
// Avalon write stage in front of the VGA framebuffer: host passthrough plus rectangle fill.
module fb_fill_engine
   import fb_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             chipselect,
   input  logic             write,
   input  logic             read,
   input  logic [15:0]      address,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             waitrequest,
   output logic [FB_AW-1:0] fb_address,
   output logic [31:0]      fb_writedata,
   output logic             fb_write
);

   state_e           state;
   logic [31:0]      pattern;
   logic [9:0]       y0, y1;
   logic [4:0]       w0, w1;
   logic             err;
   logic             busy;
   logic             host_wr, reg_wr, start_req, start_ok;
   logic [FB_AW-1:0] walk_addr;
   logic             walk_last;

   assign busy        = (state == FILL);
   assign host_wr     = chipselect & write;
   assign waitrequest = busy & host_wr;
   assign reg_wr      = host_wr & address[15] & ~busy;
   assign start_req   = reg_wr & (address[1:0] == REG_CTRL) & writedata[0];
   assign start_ok    = (y0 <= y1) && (y1 <= LAST_LINE) && (w0 <= w1) && (w1 <= LAST_WORD);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      readdata = '0;
      if (chipselect && read) begin
         readdata[STAT_BUSY] = busy;
         readdata[STAT_ERR]  = err;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pattern <= '0;
         y0      <= '0;
         y1      <= '0;
         w0      <= '0;
         w1      <= '0;
      end else if (reg_wr) begin
         case (address[1:0])
            REG_PATTERN: pattern <= writedata;
            REG_Y: begin
               y0 <= writedata[9:0];
               y1 <= writedata[25:16];
            end
            REG_W: begin
               w0 <= writedata[4:0];
               w1 <= writedata[20:16];
            end
            default: ;
         endcase
      end
   end

   fb_rect_walker u_walker (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (start_req & start_ok),
      .advance (busy & ~walk_last),
      .y0      (y0),
      .y1      (y1),
      .w0      (w0),
      .w1      (w1),
      .addr    (walk_addr),
      .last    (walk_last)
   );

   // The first fill word is presented on the start edge itself, so its address is built here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         err          <= 1'b0;
         fb_write     <= 1'b0;
         fb_address   <= '0;
         fb_writedata <= '0;
      end else begin
         fb_write <= 1'b0;
         case (state)
            IDLE: begin
               if (start_req) begin
                  if (start_ok) begin
                     state        <= FILL;
                     err          <= 1'b0;
                     fb_write     <= 1'b1;
                     fb_address   <= row_base_of(y0) + FB_AW'(w0);
                     fb_writedata <= pattern;
                  end else begin
                     err <= 1'b1;
                  end
               end else if (host_wr && !address[15]) begin
                  fb_write     <= 1'b1;
                  fb_address   <= address[FB_AW-1:0];
                  fb_writedata <= writedata;
               end
            end
            FILL: begin
               if (walk_last) begin
                  state <= IDLE;
               end else begin
                  fb_write   <= 1'b1;
                  fb_address <= walk_addr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fb_fill_engine.md
# fb_fill_engine

Host-facing write stage placed directly upstream of the 1-bpp 640x480 VGA framebuffer write port. Passes host framebuffer word writes straight through when idle. When commanded, it autonomously fills a rectangle of whole 32-bit words with a pattern, one word per clock, stalling host writes until it finishes. This offloads screen clears and band fills from software.

## Interface
Parameters:
- WORDS_PER_LINE, 20, 32-pixel words per display line (640/32)
- LINES, 480, display lines
- FB_AW, 15, framebuffer word-address width

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  reset; asynchronous, active-low
- chipselect  in  1  Avalon slave select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  16  bit 15 = 0: framebuffer word address [14:0]; bit 15 = 1: control register [1:0]
- writedata  in  32  write data
- readdata  out  32  status readback, combinational, zero wait
- waitrequest  out  1  stalls host writes while busy
- fb_address  out  FB_AW  framebuffer write address
- fb_writedata  out  32  framebuffer write data; bit i = pixel x%32 == i
- fb_write  out  1  framebuffer write enable

## Operation
- Framebuffer word address = y*WORDS_PER_LINE + word column.
- Registers at address[15]=1, writable only when idle:
  - 0 PATTERN: the fill word.
  - 1 Y: y0 [9:0], y1 [25:16].
  - 2 W: w0 [4:0], w1 [20:16].
  - 3 CTRL: a write with bit0=1 starts a fill.
  - Reads of any register return {30'b0, err, busy}.
- Start validation: the fill runs only if y0<=y1<LINES and w0<=w1<WORDS_PER_LINE. Otherwise err=1, busy stays 0 and nothing is written. A valid start clears err.
- FSM states:
  - IDLE: passthrough enabled. A valid start goes to FILL, loading row_base=y0*WORDS_PER_LINE (shift-add, no multiplier), col=w0, row=y0.
  - FILL: issues one write per cycle at row_base+col.
    - col==w1 and row<y1: col=w0, row_base+=WORDS_PER_LINE, row++.
    - col==w1 and row==y1: return to IDLE.
- Total writes = (y1-y0+1)*(w1-w0+1). The rectangle always covers whole words. No read-modify-write.
- Passthrough: in IDLE, chipselect & write & !address[15] forwards address[14:0] and writedata to fb_* unchanged.
- Arithmetic: row_base is 15 bits. Maximum 479*20+19 = 9599, so no wrap is possible.

## Timing
- All fb_* outputs are registered. Passthrough latency is 1 cycle from the accepted host write to fb_write.
- First fill write appears on fb_* 1 cycle after the CTRL start write. Subsequent writes appear on consecutive cycles with no bubbles.
- busy rises in the cycle after the start write. It falls in the cycle after the last fill write is presented.
- waitrequest = busy & chipselect & write. Host writes of any kind are held, not dropped, and complete in the first idle cycle. Reads never stall.
- If a start write and a passthrough write occur in the same cycle, that is impossible (one bus). A start while busy is stalled like any other write.
- Reset values: fb_write=0, fb_address=0, fb_writedata=0, waitrequest=0, busy=0, err=0, all registers 0, FSM IDLE.
- Reset asserted mid-fill aborts immediately. No further fb_write. Remaining words are left unwritten.

## Structure
- Package fb_pkg: WORDS_PER_LINE, LINES, FB_AW, register offsets (REG_PATTERN, REG_Y, REG_W, REG_CTRL), status bit positions, and a state enum {IDLE, FILL}.
- One sub-module, fb_rect_walker: holds the row/column counters and row_base accumulator, with the outputs addr, last, and an advance input. The top level holds the registers, validation, FSM, passthrough mux and output registers.

## Test plan
- Passthrough: idle; host writes address 0x0005, data 0xA5A5A5A5 -> next cycle fb_write=1, fb_address=5, fb_writedata=0xA5A5A5A5.
- Single word: PATTERN=0xFFFFFFFF, y0=y1=2, w0=w1=3, start -> exactly one write at address 43. busy is high for 1 cycle.
- Full clear: PATTERN=0, y 0..479, w 0..19 -> 9600 consecutive writes at addresses 0..9599 in order. busy falls on cycle 9601.
- Band: y 10..11, w 18..19 -> writes to 218, 219, 238, 239 on consecutive cycles.
- Invalid: y0=5, y1=4 start -> no fb_write. Status reads 0x2. A subsequent valid start reads 0x1, then 0x0 when done.
- Stall/reset: a host write during a fill is held with waitrequest=1 until busy falls, then forwarded once. Asserting reset_n low mid-fill -> fb_write=0 immediately, status reads 0x0.
